// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI target-bus arbiter.
package pci_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  // C/BE bus command encodings seen on the RAM target bus
  localparam logic [3:0] CMD_IO_READ   = 4'b0010;
  localparam logic [3:0] CMD_IO_WRITE  = 4'b0011;
  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam int DEF_START_TMO = 16;
  localparam int DEF_MAX_BURST = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pci_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(ptr) + off) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin bus arbiter with start timeout and burst-latency preemption.
// Optional bus parking on the last owner when PCI_ARB_PARK_EN is defined.
module pci_bus_arbiter
  import pci_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int START_TMO = DEF_START_TMO,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_n,
  input  logic                       frame,
  output logic [NUM_REQ-1:0]         gnt_n,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       owner_vld,
  output logic                       bus_busy,
  output logic                       tmo_err
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(START_TMO, MAX_BURST) + 1);

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [CNT_W-1:0]   start_cnt;
  logic [CNT_W-1:0]   burst_cnt;
  logic [CNT_W-1:0]   start_nxt;
  logic [CNT_W-1:0]   burst_nxt;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               other_req;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] cur);
    return (int'(cur) == NUM_REQ - 1) ? '0 : cur + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (~req_n),
    .ptr    (rr_ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign start_nxt = start_cnt + 1'b1;
  assign burst_nxt = (burst_cnt >= CNT_W'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
  // The owner's own request is ignored when deciding whether to preempt
  assign other_req = |(~req_n & ~(NUM_REQ'(1) << owner));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt_n     <= '1;
      owner     <= '0;
      owner_vld <= 1'b0;
      bus_busy  <= 1'b0;
      tmo_err   <= 1'b0;
      rr_ptr    <= '0;
      start_cnt <= '0;
      burst_cnt <= '0;
    end else begin
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          // A frame seen here belongs to an ungranted (or parked) master
          if (!frame) begin
            state     <= BUSY;
            owner_vld <= 1'b1;
            bus_busy  <= 1'b1;
            burst_cnt <= '0;
          end else if (win_any) begin
`ifdef PCI_ARB_PARK_EN
            if (gnt_n != '1 && win_idx != owner) begin
              gnt_n     <= '1;
              owner_vld <= 1'b0;
            end else
`endif
            begin
              gnt_n     <= ~win_onehot;
              owner     <= win_idx;
              owner_vld <= 1'b1;
              start_cnt <= '0;
              state     <= GRANT;
            end
          end
`ifdef PCI_ARB_PARK_EN
          else begin
            gnt_n     <= ~(NUM_REQ'(1) << owner);
            owner_vld <= 1'b1;
          end
`endif
        end
        GRANT: begin
          if (!frame) begin
            state     <= BUSY;
            bus_busy  <= 1'b1;
            burst_cnt <= '0;
          end else if (req_n[owner]) begin
            state     <= IDLE;
            gnt_n     <= '1;
            owner_vld <= 1'b0;
          end else if (start_nxt >= CNT_W'(START_TMO)) begin
            state     <= IDLE;
            gnt_n     <= '1;
            owner_vld <= 1'b0;
            tmo_err   <= 1'b1;
            rr_ptr    <= next_ptr(owner);
          end else begin
            start_cnt <= start_nxt;
          end
        end
        BUSY: begin
          if (frame) begin
            state     <= TURN;
            gnt_n     <= '1;
            owner_vld <= 1'b0;
            rr_ptr    <= next_ptr(owner);
          end else begin
            burst_cnt <= burst_nxt;
            if (burst_nxt >= CNT_W'(MAX_BURST) && other_req)
              gnt_n[owner] <= 1'b1;
          end
        end
        TURN: begin
          state    <= IDLE;
          bus_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed self-checking bench for pci_bus_arbiter (NUM_REQ=4, START_TMO=16, MAX_BURST=32).
module tb_pci_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_n;
  logic       frame;
  logic [3:0] gnt_n;
  logic [1:0] owner;
  logic       owner_vld;
  logic       bus_busy;
  logic       tmo_err;

  int total = 0;
  int bad   = 0;

  pci_bus_arbiter #(.NUM_REQ(4), .START_TMO(16), .MAX_BURST(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_n     (req_n),
    .frame     (frame),
    .gnt_n     (gnt_n),
    .owner     (owner),
    .owner_vld (owner_vld),
    .bus_busy  (bus_busy),
    .tmo_err   (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    req_n = 4'b1111;
    frame = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    req_n = 4'b1111;
    frame = 1'b1;
    repeat (2) tick();
    total++; if (gnt_n !== 4'b1111) begin bad++; $display("[TB] FAIL reset_gnt: got %b want 1111", gnt_n); end
    total++; if (owner !== 2'd0) begin bad++; $display("[TB] FAIL reset_owner: got %0d want 0", owner); end
    total++; if (owner_vld !== 1'b0 || bus_busy !== 1'b0 || tmo_err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_flags: vld=%b busy=%b tmo=%b want 000", owner_vld, bus_busy, tmo_err);
    end
    rst = 1'b1;
    tick();
    total++; if (gnt_n !== 4'b1111) begin bad++; $display("[TB] FAIL idle_gnt: got %b want 1111", gnt_n); end
  endtask

  task automatic test_basic();
    do_reset();
    req_n = 4'b1110;
    tick();
    total++; if (gnt_n !== 4'b1110 || owner !== 2'd0 || owner_vld !== 1'b1) begin
      bad++; $display("[TB] FAIL basic_grant: gnt=%b owner=%0d vld=%b want 1110/0/1", gnt_n, owner, owner_vld);
    end
    req_n = 4'b1111;
    frame = 1'b0;
    tick();
    total++; if (bus_busy !== 1'b1 || gnt_n !== 4'b1110) begin
      bad++; $display("[TB] FAIL basic_busy: busy=%b gnt=%b want 1/1110", bus_busy, gnt_n);
    end
    repeat (2) tick();
    frame = 1'b1;
    tick();
    total++; if (gnt_n !== 4'b1111 || bus_busy !== 1'b1 || owner_vld !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_turn: gnt=%b busy=%b vld=%b want 1111/1/0", gnt_n, bus_busy, owner_vld);
    end
    req_n = 4'b1100;
    tick();
    total++; if (gnt_n !== 4'b1111 || bus_busy !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_idle: gnt=%b busy=%b want 1111/0", gnt_n, bus_busy);
    end
    tick();
    total++; if (gnt_n !== 4'b1101 || owner !== 2'd1) begin
      bad++; $display("[TB] FAIL basic_ptr: gnt=%b owner=%0d want 1101/1", gnt_n, owner);
    end
    req_n = 4'b1111;
    tick();
    total++; if (gnt_n !== 4'b1111 || owner_vld !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_withdraw: gnt=%b vld=%b want 1111/0", gnt_n, owner_vld);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt;
    do_reset();
    req_n = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      exp_gnt = ~(4'b0001 << (i % 4));
      tick();
      total++; if (gnt_n !== exp_gnt || owner !== 2'(i % 4)) begin
        bad++; $display("[TB] FAIL rot_grant%0d: gnt=%b owner=%0d want %b/%0d", i, gnt_n, owner, exp_gnt, i % 4);
      end
      frame = 1'b0;
      repeat (2) tick();
      total++; if (bus_busy !== 1'b1 || gnt_n !== exp_gnt) begin
        bad++; $display("[TB] FAIL rot_busy%0d: busy=%b gnt=%b want 1/%b", i, bus_busy, gnt_n, exp_gnt);
      end
      frame = 1'b1;
      tick();
      total++; if (gnt_n !== 4'b1111 || bus_busy !== 1'b1) begin
        bad++; $display("[TB] FAIL rot_turn%0d: gnt=%b busy=%b want 1111/1", i, gnt_n, bus_busy);
      end
      tick();
      total++; if (gnt_n !== 4'b1111 || bus_busy !== 1'b0) begin
        bad++; $display("[TB] FAIL rot_idle%0d: gnt=%b busy=%b want 1111/0", i, gnt_n, bus_busy);
      end
    end
    req_n = 4'b1111;
  endtask

  task automatic test_timeout();
    do_reset();
    req_n = 4'b0011;
    tick();
    total++; if (gnt_n !== 4'b1011 || owner !== 2'd2) begin
      bad++; $display("[TB] FAIL tmo_grant: gnt=%b owner=%0d want 1011/2", gnt_n, owner);
    end
    for (int c = 1; c < 16; c++) begin
      tick();
      total++; if (gnt_n !== 4'b1011 || tmo_err !== 1'b0) begin
        bad++; $display("[TB] FAIL tmo_wait%0d: gnt=%b tmo=%b want 1011/0", c, gnt_n, tmo_err);
      end
    end
    tick();
    total++; if (tmo_err !== 1'b1 || gnt_n !== 4'b1111 || owner_vld !== 1'b0) begin
      bad++; $display("[TB] FAIL tmo_fire: tmo=%b gnt=%b vld=%b want 1/1111/0", tmo_err, gnt_n, owner_vld);
    end
    tick();
    total++; if (tmo_err !== 1'b0 || gnt_n !== 4'b0111 || owner !== 2'd3) begin
      bad++; $display("[TB] FAIL tmo_next: tmo=%b gnt=%b owner=%0d want 0/0111/3", tmo_err, gnt_n, owner);
    end
    req_n = 4'b1111;
    tick();
  endtask

  task automatic test_preempt();
    logic [3:0] exp_gnt;
    do_reset();
    req_n = 4'b1110;
    tick();
    total++; if (gnt_n !== 4'b1110) begin bad++; $display("[TB] FAIL pre_grant: gnt=%b want 1110", gnt_n); end
    req_n = 4'b1100;
    frame = 1'b0;
    tick();
    for (int j = 1; j < 40; j++) begin
      tick();
      exp_gnt = (j < 32) ? 4'b1110 : 4'b1111;
      total++; if (gnt_n !== exp_gnt || bus_busy !== 1'b1) begin
        bad++; $display("[TB] FAIL pre_burst%0d: gnt=%b busy=%b want %b/1", j, gnt_n, bus_busy, exp_gnt);
      end
    end
    frame = 1'b1;
    tick();
    total++; if (gnt_n !== 4'b1111 || bus_busy !== 1'b1) begin
      bad++; $display("[TB] FAIL pre_turn: gnt=%b busy=%b want 1111/1", gnt_n, bus_busy);
    end
    tick();
    total++; if (gnt_n !== 4'b1111) begin bad++; $display("[TB] FAIL pre_gap: gnt=%b want 1111", gnt_n); end
    tick();
    total++; if (gnt_n !== 4'b1101 || owner !== 2'd1) begin
      bad++; $display("[TB] FAIL pre_next: gnt=%b owner=%0d want 1101/1", gnt_n, owner);
    end
    req_n = 4'b1111;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_n = 4'b1101;
    tick();
    req_n = 4'b1111;
    frame = 1'b0;
    tick();
    frame = 1'b1;
    repeat (2) tick();
    req_n = 4'b1011;
    tick();
    total++; if (gnt_n !== 4'b1011) begin bad++; $display("[TB] FAIL rmid_grant: gnt=%b want 1011", gnt_n); end
    frame = 1'b0;
    repeat (2) tick();
    #2;
    rst = 1'b0;
    #1;
    total++; if (gnt_n !== 4'b1111 || owner_vld !== 1'b0 || bus_busy !== 1'b0) begin
      bad++; $display("[TB] FAIL rmid_async: gnt=%b vld=%b busy=%b want 1111/0/0", gnt_n, owner_vld, bus_busy);
    end
    frame = 1'b1;
    req_n = 4'b1111;
    tick();
    rst   = 1'b1;
    req_n = 4'b0000;
    tick();
    total++; if (gnt_n !== 4'b1110 || owner !== 2'd0) begin
      bad++; $display("[TB] FAIL rmid_ptr: gnt=%b owner=%0d want 1110/0", gnt_n, owner);
    end
    req_n = 4'b1111;
    tick();
  endtask

`ifdef PCI_ARB_PARK_EN
  task automatic test_park();
    do_reset();
    tick();
    total++; if (gnt_n !== 4'b1110 || owner_vld !== 1'b1) begin
      bad++; $display("[TB] FAIL park_reset: gnt=%b vld=%b want 1110/1", gnt_n, owner_vld);
    end
    req_n = 4'b1011;
    tick();
    total++; if (gnt_n !== 4'b1111) begin bad++; $display("[TB] FAIL park_gap: gnt=%b want 1111", gnt_n); end
    tick();
    total++; if (gnt_n !== 4'b1011) begin bad++; $display("[TB] FAIL park_move: gnt=%b want 1011", gnt_n); end
    req_n = 4'b1111;
    frame = 1'b0;
    repeat (2) tick();
    frame = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (gnt_n !== 4'b1011 || owner_vld !== 1'b1) begin
        bad++; $display("[TB] FAIL park_hold%0d: gnt=%b vld=%b want 1011/1", k, gnt_n, owner_vld);
      end
    end
    frame = 1'b0;
    tick();
    total++; if (bus_busy !== 1'b1 || owner !== 2'd2) begin
      bad++; $display("[TB] FAIL park_busy: busy=%b owner=%0d want 1/2", bus_busy, owner);
    end
    frame = 1'b1;
    repeat (3) tick();
  endtask
`endif

  initial begin
    rst   = 1'b0;
    req_n = 4'b1111;
    frame = 1'b1;
    test_reset();
`ifdef PCI_ARB_PARK_EN
    test_park();
`else
    test_basic();
    test_rotation();
    test_timeout();
    test_preempt();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
